serial_pattern_tx: RTL

SERIAL_PATTERN_TX -- requirements
Module: serial_pattern_tx

---
 rtl/serial_pattern_tx.sv | 104 ++++++++++
 1 files changed

// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: sends pat[len-1:0] MSB first, (reps+1) frames, first bit the cycle after the handshake.
// Accepts a request only in IDLE (start_ready); define SEQ_GAP_EN for one idle cycle between consecutive frames.
module serial_pattern_tx #(
  parameter int PAT_W = 8,
  parameter int LEN_W = 4,
  parameter int REP_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [PAT_W-1:0] pat,
  input  logic [LEN_W-1:0] len,
  input  logic [REP_W-1:0] reps,
  output logic             x,
  output logic             x_valid,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP, DONE} state_t;

  localparam logic [LEN_W-1:0] PAT_LEN = LEN_W'(PAT_W);
  localparam logic [LEN_W-1:0] ONE     = LEN_W'(1);

  state_t           state, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [REP_W-1:0] rep_q, rep_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [PAT_W-1:0] sr_q, sr_d;
  logic [LEN_W-1:0] len_c;

  assign len_c = (len > PAT_LEN) ? PAT_LEN : len;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pat_q <= '0;
      len_q <= '0;
      rep_q <= '0;
      cnt_q <= '0;
      sr_q  <= '0;
    end else begin
      state <= state_d;
      pat_q <= pat_d;
      len_q <= len_d;
      rep_q <= rep_d;
      cnt_q <= cnt_d;
      sr_q  <= sr_d;
    end
  end

  // The shift register holds the active field left-aligned so x is always its MSB.
  always_comb begin
    state_d = state;
    pat_d   = pat_q;
    len_d   = len_q;
    rep_d   = rep_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    case (state)
      IDLE: begin
        if (start_valid) begin
          pat_d = pat;
          len_d = len_c;
          rep_d = reps;
          cnt_d = len_c - ONE;
          sr_d  = pat << (PAT_LEN - len_c);
          state_d = (len_c == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        sr_d = sr_q << 1;
        if (cnt_q == '0) begin
          if (rep_q != '0) begin
            rep_d = rep_q - REP_W'(1);
            cnt_d = len_q - ONE;
            sr_d  = pat_q << (PAT_LEN - len_q);
`ifdef SEQ_GAP_EN
            state_d = GAP;
`else
            state_d = SHIFT;
`endif
          end else begin
            state_d = DONE;
          end
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      GAP:     state_d = SHIFT;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign start_ready = (state == IDLE);
  assign x_valid     = (state == SHIFT);
  assign x           = x_valid & sr_q[PAT_W-1];
  assign busy        = (state != IDLE);
  assign done        = (state == DONE);

endmodule
